line_pingpong_sched: RTL and testbench

LINE_PINGPONG_SCHED -- requirements
Module: line_pingpong_sched

---
 rtl/line_pingpong_sched_pkg.sv | 11 +
 rtl/line_pingpong_sched_skid2.sv | 43 ++++
 rtl/line_pingpong_sched.sv | 169 ++++++++++++++++
 tb/tb_line_pingpong_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pingpong_sched_pkg.sv
// Shared encodings and default geometry for the ping-pong line scheduler.
package line_pingpong_sched_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 11;
  localparam int LINE_MAX_DEF = 1280;

  typedef enum logic [1:0] {W_IDLE, W_LINE, W_HOLD, W_GAP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DRAIN} rd_state_t;

endpackage

// File: rtl/line_pingpong_sched_skid2.sv
// Two-entry skid FIFO that absorbs line-RAM read data while the output is stalled.
module lps_skid2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/line_pingpong_sched.sv
// Writes one line into the ping-pong RAM while streaming the previous line back out.
//   state   | meaning
//   W_IDLE  | waiting for the first pixel of a line
//   W_LINE  | writing a line; ram_we held high through input gaps
//   W_HOLD  | line complete, read side still busy with the previous line
//   W_GAP   | single ram_we-low cycle that swaps banks and arms the reader
//   R_IDLE  | nothing to read
//   R_READ  | issuing reads 0..rlen-1 under a two-word credit
//   R_DRAIN | all reads issued, waiting for skid FIFO and in-flight read to empty
module line_pingpong_sched
  import line_pingpong_sched_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINE_MAX = LINE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              line_done
);

  localparam int LEN_W = ADDR_W + 1;

  wr_state_t         r_wstate, w_wnext;
  rd_state_t         r_rstate, w_rnext;
  logic [LEN_W-1:0]  r_wcnt, r_wlen, r_rlen, r_raddr;
  logic [ADDR_W-1:0] r_laddr;
  logic [DATA_W-1:0] r_ldata;
  logic              r_infl, r_infl_last;

  logic [LEN_W-1:0]  w_cur_addr;
  logic              w_acc, w_line_end, w_rd_idle, w_re, w_pop, w_sk_valid;
  logic [1:0]        w_sk_cnt;
  logic [2:0]        w_busy;
  logic              w_rd_last;

  assign w_cur_addr = (r_wstate == W_IDLE) ? '0 : r_wcnt;
  assign w_acc      = in_valid && !reset && (r_wstate == W_IDLE || r_wstate == W_LINE);
  assign w_line_end = w_acc && (in_last || w_cur_addr == LEN_W'(LINE_MAX - 1));
  assign w_rd_idle  = (r_rstate == R_IDLE);

  always_comb begin
    w_wnext   = r_wstate;
    in_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = r_laddr;
    ram_wdata = r_ldata;
    line_done = 1'b0;
    case (r_wstate)
      W_IDLE, W_LINE: begin
        in_ready = 1'b1;
        ram_we   = (r_wstate == W_LINE) || in_valid;
        if (in_valid) begin
          ram_waddr = w_cur_addr[ADDR_W-1:0];
          ram_wdata = in_data;
          w_wnext   = W_LINE;
        end
        if (w_line_end) w_wnext = w_rd_idle ? W_GAP : W_HOLD;
      end
      W_HOLD: begin
        ram_we = 1'b1;
        if (w_rd_idle) w_wnext = W_GAP;
      end
      W_GAP: begin
        line_done = 1'b1;
        w_wnext   = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
    if (reset) begin
      in_ready  = 1'b0;
      ram_we    = 1'b0;
      ram_waddr = '0;
      line_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= '0;
      r_wlen   <= '0;
      r_laddr  <= '0;
      r_ldata  <= '0;
    end else begin
      r_wstate <= w_wnext;
      if (w_acc) begin
        r_laddr <= w_cur_addr[ADDR_W-1:0];
        r_ldata <= in_data;
        r_wcnt  <= w_cur_addr + LEN_W'(1);
      end
      if (w_line_end) r_wlen <= w_cur_addr + LEN_W'(1);
    end
  end

  // Credit counts this cycle's pop so a steady stream keeps one read per cycle.
  assign w_pop     = out_valid && out_ready;
  assign w_busy    = {1'b0, w_sk_cnt} + {2'b00, r_infl} - {2'b00, w_pop};
  assign w_rd_last = (r_raddr == r_rlen - LEN_W'(1));

  always_comb begin
    w_rnext = r_rstate;
    w_re    = 1'b0;
    case (r_rstate)
      R_IDLE:  if (r_wstate == W_GAP) w_rnext = R_READ;
      R_READ: begin
        if (w_busy < 3'd2) begin
          w_re = 1'b1;
          if (w_rd_last) w_rnext = R_DRAIN;
        end
      end
      R_DRAIN: if (w_sk_cnt == 2'd0 && !r_infl) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
    if (reset) w_re = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate    <= R_IDLE;
      r_rlen      <= '0;
      r_raddr     <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_rstate    <= w_rnext;
      r_infl      <= w_re;
      r_infl_last <= w_re && w_rd_last;
      if (r_wstate == W_GAP) r_rlen <= r_wlen;
      if (r_rstate == R_IDLE) r_raddr <= '0;
      else if (w_re)          r_raddr <= r_raddr + LEN_W'(1);
    end
  end

  assign ram_re    = w_re;
  assign ram_raddr = r_raddr[ADDR_W-1:0];

  logic [DATA_W:0] w_sk_data;

  lps_skid2 #(.W(DATA_W + 1)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_infl),
    .i_data  ({r_infl_last, ram_rdata}),
    .i_pop   (w_pop),
    .o_valid (w_sk_valid),
    .o_data  (w_sk_data),
    .o_count (w_sk_cnt)
  );

  assign out_valid = w_sk_valid && !reset;
  assign out_data  = w_sk_data[DATA_W-1:0];
  assign out_last  = w_sk_data[DATA_W];

endmodule

// File: tb/tb_line_pingpong_sched.sv
// Scoreboard bench: driver queues each completed input line, monitor checks the output stream.
module tb_line_pingpong_sched;
  localparam int DW = 8;
  localparam int AW = 11;
  localparam int LM = 1280;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data;
  logic          ram_we, ram_re, line_done;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  line_pingpong_sched #(.DATA_W(DW), .ADDR_W(AW), .LINE_MAX(LM)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .line_done(line_done)
  );

  // Ping-pong RAM: bank swap on ram_we falling, toggle shares the block reset.
  logic [DW-1:0] mem0 [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic tog, prev_we;
  always @(posedge clk) begin
    if (reset) begin
      tog <= 1'b0; prev_we <= 1'b0;
    end else begin
      prev_we <= ram_we;
      if (prev_we && !ram_we) tog <= ~tog;
    end
    if (ram_we) begin
      if (tog) mem1[ram_waddr] <= ram_wdata;
      else     mem0[ram_waddr] <= ram_wdata;
    end
    if (ram_re) ram_rdata <= tog ? mem0[ram_raddr] : mem1[ram_raddr];
  end

  int tests = 0;
  int fails = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] cur_q[$];
  int cur_cnt = 0;
  int lines_ended = 0;
  int ld_seen = 0;
  int rdy_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       out_ready = ($urandom % 2) == 0;
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  logic mon_prev_we = 1'b0;
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", int'(out_data), -1);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), int'(e[DW-1:0]));
          chk("out_last", int'(out_last), int'(e[DW]));
        end
      end
      if (line_done) ld_seen++;
      if (mon_prev_we && !ram_we) chk("we_fall_only_in_gap", int'(line_done), 1);
      mon_prev_we = ram_we;
    end else begin
      mon_prev_we = 1'b0;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic l, output int wa);
    bit acc = 0;
    int n = 0;
    logic eff;
    wa = -1;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!acc && n < 3000) begin
      @(negedge clk);
      if (in_ready) begin acc = 1; wa = int'(ram_waddr); end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      chk("in_ready_timeout", 0, 1);
    end else begin
      cur_cnt++;
      eff = l || (cur_cnt == LM);
      cur_q.push_back({eff, d});
      if (eff) begin
        foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
        cur_q.delete();
        cur_cnt = 0;
        lines_ended++;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap_check(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("we_held_in_gap", int'(ram_we), 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_line(input int len, input int base);
    int wa;
    for (int i = 0; i < len; i++) send(DW'(base + i), (i == len - 1), wa);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    in_valid = 1'b0; in_last = 1'b0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk); n++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
    chk({name, "_line_done"}, ld_seen, lines_ended);
  endtask

  initial begin
    int wa, ld0, len;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_re", int'(ram_re), 0);
    chk("rst_line_done", int'(line_done), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_waddr", int'(ram_waddr), 0);
    @(posedge clk); #1;

    // four back-to-back 4-pixel lines
    for (int k = 0; k < 4; k++) send_line(4, 16 * (k + 1));
    wait_drain("lines4x4");

    // mid-line input gaps
    send(8'hA0, 1'b0, wa); send(8'hA1, 1'b0, wa);
    gap_check(3);
    send(8'hA2, 1'b0, wa); send(8'hA3, 1'b0, wa); send(8'hA4, 1'b0, wa);
    gap_check(3);
    send(8'hA5, 1'b0, wa); send(8'hA6, 1'b1, wa);
    send_line(3, 8'hB0);
    wait_drain("gaps");

    // output stalled while the next line completes
    rdy_mode = 2;
    send_line(6, 8'h40);
    send_line(6, 8'h50);
    ld0 = ld_seen;
    idle(5);
    @(negedge clk);
    chk("hold_in_ready", int'(in_ready), 0);
    chk("hold_ram_we", int'(ram_we), 1);
    chk("hold_out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    idle(12);
    chk("hold_no_line_done", ld_seen, ld0);
    rdy_mode = 0;
    wait_drain("hold");

    // 1300 pixels, no in_last until the end: forced split at LINE_MAX
    for (int i = 0; i < 1300; i++) begin
      send(DW'(i * 7), (i == 1299), wa);
      if (i == 1279) chk("addr_pix1280", wa, 1279);
      if (i == 1280) chk("addr_pix1281_restart", wa, 0);
    end
    wait_drain("line_max");

    // random lengths with 50% out_ready
    rdy_mode = 1;
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) send(DW'($urandom), (i == len - 1), wa);
      if (($urandom % 3) == 0) idle($urandom_range(1, 4));
    end
    wait_drain("random");
    rdy_mode = 0;

    // reset in the middle of a line
    for (int i = 0; i < 5; i++) send(DW'(8'hE0 + i), 1'b0, wa);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cur_q.delete(); cur_cnt = 0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_ram_we", int'(ram_we), 0);
    chk("midrst_ram_re", int'(ram_re), 0);
    chk("midrst_line_done", int'(line_done), 0);
    chk("midrst_in_ready_after", int'(in_ready), 1);
    @(posedge clk); #1;
    send_line(5, 8'hC0);
    send_line(3, 8'hD0);
    wait_drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
